tmr_fault_manager: RTL
======================

Name: tmr_fault_manager

Overview:
Supervisory sequencer for the triplicated (TMR) datapath blocks.
- Collects the per-voter "detected" mismatch flags and keeps sticky per-source status and a saturating event count.
- Drives a request/acknowledge resynchronisation of the replicas, then checks in a cooldown window whether the mismatch has cleared.
- Retries a bounded number of times, then escalates to a latched alarm that only software can clear.

Parameters:
N_SRC, 5, number of voter fault-flag inputs
CNT_W, 16, width of the total fault-event counter
COOLDOWN, 8, cycles to observe after a resync acknowledge (>=1)
MAX_RETRY, 3, consecutive failed resync attempts before FAILED (>=1)
ACK_TIMEOUT, 16, maximum cycles resync_req_o may wait for resync_ack_i (>=1)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
fault_i  in  N_SRC  voter detected flags, level, sampled each rising edge
enable_i  in  1  allows new resync sequences to start from IDLE
clear_i  in  1  single-cycle pulse: clear status, count and alarm
resync_ack_i  in  1  replica resync complete
resync_req_o  out  1  request to resync replicas
busy_o  out  1  FSM not in IDLE
alarm_o  out  1  unrecoverable fault, latched
status_o  out  N_SRC  sticky per-source fault bits
fault_count_o  out  CNT_W  cycles with any fault asserted, saturating
retry_cnt_o  out  $clog2(MAX_RETRY+1)  failed attempts in the current episode

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all outputs 0; internal timers 0.
- Signal definitions:
  - any_f = |fault_i.
  - All outputs are registered. Responses appear on the cycle after the sampling edge.
- Status and count update on every cycle, in every state:
  - status_o <= status_o | fault_i.
  - fault_count_o <= fault_count_o + any_f, saturating at 2^CNT_W-1.
- clear_i handling:
  - status_o <= fault_i.
  - fault_count_o <= any_f (count restarts at 0, then adds this cycle's event). A fault in the same cycle therefore wins over the clear.
  - In FAILED: alarm_o<=0, retry_cnt<=0, state<=IDLE.
  - In any other state: the FSM is unaffected.
- FSM states:
  - IDLE: if any_f && enable_i, go to RESYNC. resync_req_o is 1 on the next cycle.
  - RESYNC: resync_req_o=1 and timer counts.
    - If resync_ack_i, go to COOLDOWN; resync_req_o drops on the next cycle.
    - Else if timer reaches ACK_TIMEOUT-1 without ack, go to FAILED.
    - Ack arriving in the same cycle the timeout hits: ack wins.
  - COOLDOWN: runs COOLDOWN cycles and records seen = OR of any_f over the window. On the last cycle:
    - seen=0: retry_cnt<=0, go to IDLE.
    - seen=1 and retry_cnt+1 == MAX_RETRY: retry_cnt<=MAX_RETRY, go to FAILED.
    - seen=1 otherwise: retry_cnt<=retry_cnt+1, go to RESYNC.
  - FAILED: alarm_o=1, resync_req_o=0. Leaves only on clear_i or reset.
- Handshake rules:
  - resync_req_o stays high until ack is sampled.
  - resync_ack_i is ignored outside RESYNC.
  - Once the FSM has left IDLE, enable_i does not affect it. A started sequence always completes.
- busy_o = (state != IDLE). FAILED counts as busy.
- Faults are never lost. Faults present during RESYNC or FAILED still update status and count.
- Reset mid-sequence immediately returns IDLE and drops resync_req_o. No residual request is held.

Test Plan:
1. Single fault pulse, ack 3 cycles later, no further faults:
   - fault_i=5'b00100 for 1 cycle, enable_i=1.
   - resync_req_o high 1 cycle after the pulse and held 3 cycles.
   - COOLDOWN 8 cycles, then IDLE.
   - status_o=00100, fault_count_o=1, retry_cnt_o=0, alarm_o=0.
2. Persistent fault, fault_i=5'b00001 held high, ack always 1 cycle after request:
   - Three resync attempts; retry_cnt_o steps 1, 2, 3.
   - FAILED with alarm_o=1.
   - fault_count_o equals the number of asserted cycles.
3. No ack:
   - Fault triggers RESYNC with resync_ack_i=0.
   - After 16 cycles: FAILED, alarm_o=1, resync_req_o=0.
   - clear_i pulse: IDLE, alarm_o=0, status_o=0, count=0.
4. Simultaneous clear_i and fault_i=5'b10000 in the same cycle, with prior count 7:
   - Next cycle: fault_count_o=1, status_o=10000.
5. enable_i=0 with fault_i=5'b00010 for 2 cycles:
   - No resync_req_o; busy_o=0.
   - status_o=00010, fault_count_o=2.
6. Saturation with CNT_W=4:
   - Fault held 20 cycles during FAILED.
   - fault_count_o stays at 15.
   - Async reset mid-RESYNC: all outputs 0 immediately.

Source files
------------

// File: rtl/tmr_fault_manager.sv
// Supervisory sequencer for the TMR voters. It keeps sticky fault status and a saturating event
// count, requests replica resyncs, retries a bounded number of times, then latches an alarm.
module tmr_fault_manager #(
  parameter int N_SRC       = 5,
  parameter int CNT_W       = 16,
  parameter int COOLDOWN    = 8,
  parameter int MAX_RETRY   = 3,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N_SRC-1:0]             fault_i,
  input  logic                         enable_i,
  input  logic                         clear_i,
  input  logic                         resync_ack_i,
  output logic                         resync_req_o,
  output logic                         busy_o,
  output logic                         alarm_o,
  output logic [N_SRC-1:0]             status_o,
  output logic [CNT_W-1:0]             fault_count_o,
  output logic [$clog2(MAX_RETRY+1)-1:0] retry_cnt_o
);

  localparam int RC_W = $clog2(MAX_RETRY + 1);
  localparam int TMAX = (COOLDOWN > ACK_TIMEOUT) ? COOLDOWN : ACK_TIMEOUT;
  localparam int TM_W = $clog2(TMAX + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_RESYNC, ST_COOLDOWN, ST_FAILED} state_e;

  state_e            state_q, state_d;
  logic [TM_W-1:0]   timer_q, timer_d;
  logic              seen_q, seen_d;
  logic [RC_W-1:0]   retry_q, retry_d;
  logic [N_SRC-1:0]  status_q, status_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              req_q, req_d;
  logic              busy_q, busy_d;
  logic              alarm_q, alarm_d;
  logic              any_f;

  assign any_f = |fault_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      timer_q  <= '0;
      seen_q   <= 1'b0;
      retry_q  <= '0;
      status_q <= '0;
      count_q  <= '0;
      req_q    <= 1'b0;
      busy_q   <= 1'b0;
      alarm_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      seen_q   <= seen_d;
      retry_q  <= retry_d;
      status_q <= status_d;
      count_q  <= count_d;
      req_q    <= req_d;
      busy_q   <= busy_d;
      alarm_q  <= alarm_d;
    end
  end

  // Status and count track faults in every state; a clear restarts them from this cycle's faults.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    seen_d   = seen_q;
    retry_d  = retry_q;
    status_d = clear_i ? fault_i : (status_q | fault_i);
    if (clear_i)
      count_d = CNT_W'(any_f);
    else if (any_f && (count_q != '1))
      count_d = count_q + CNT_W'(1);
    else
      count_d = count_q;

    case (state_q)
      ST_IDLE: begin
        if (any_f && enable_i) begin
          state_d = ST_RESYNC;
          timer_d = '0;
        end
      end
      ST_RESYNC: begin
        if (resync_ack_i) begin
          state_d = ST_COOLDOWN;
          timer_d = '0;
          seen_d  = 1'b0;
        end else if (timer_q == TM_W'(ACK_TIMEOUT - 1)) begin
          state_d = ST_FAILED;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TM_W'(1);
        end
      end
      ST_COOLDOWN: begin
        seen_d = seen_q | any_f;
        if (timer_q == TM_W'(COOLDOWN - 1)) begin
          timer_d = '0;
          if (!(seen_q | any_f)) begin
            retry_d = '0;
            state_d = ST_IDLE;
          end else if (retry_q == RC_W'(MAX_RETRY - 1)) begin
            retry_d = RC_W'(MAX_RETRY);
            state_d = ST_FAILED;
          end else begin
            retry_d = retry_q + RC_W'(1);
            state_d = ST_RESYNC;
          end
        end else begin
          timer_d = timer_q + TM_W'(1);
        end
      end
      ST_FAILED: begin
        if (clear_i) begin
          retry_d = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they are registered yet line up with state_q.
  always_comb begin
    req_d   = (state_d == ST_RESYNC);
    busy_d  = (state_d != ST_IDLE);
    alarm_d = (state_d == ST_FAILED);
  end

  assign resync_req_o  = req_q;
  assign busy_o        = busy_q;
  assign alarm_o       = alarm_q;
  assign status_o      = status_q;
  assign fault_count_o = count_q;
  assign retry_cnt_o   = retry_q;

endmodule
